// File: rtl/bc_miner_core.sv
// bc_miner_core -- Bitcoin proof-of-work nonce search engine.
//
// Takes a block-header job from the block store (SHA-256 midstate H0..H7,
// then the three tail header words W0..W2) and walks the nonce range, computing
// SHA256(SHA256(header)) on one shared iterative round engine (1 round/cycle).
// The first nonce whose little-endian hash has TARGET_ZEROS leading zero bits is
// written to the nonce buffer. Every nonce takes exactly 130 cycles.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous reset, active-low
//   blk_valid    block-store word strobe (one word per high cycle)
//   blk_data     job word: H0..H7, then tail W0, W1, W2
//   resultValid  one-cycle pulse when a search finishes
//   success      qualifies resultValid (1 = nonce found); held until next job
//   non_valid    one-cycle write strobe into the nonce buffer
//   non_data     winning nonce (numeric value, not byte-swapped)
module bc_miner_core #(
  parameter int unsigned TARGET_ZEROS = 32,
  parameter logic [31:0] NONCE_START  = 32'h0000_0000,
  parameter logic [31:0] NONCE_END    = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        blk_valid,
  input  logic [31:0] blk_data,
  output logic        resultValid,
  output logic        success,
  output logic        non_valid,
  output logic [31:0] non_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_HASH1,
    S_HASH2,
    S_CHECK,
    S_DONE
  } state_e;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  // Bits of byteswap(D7) that must be zero for a winning hash.
  localparam logic [31:0] ZMASK = ~(32'hFFFF_FFFF >> TARGET_ZEROS);

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  state_e      state_q, state_d;
  logic [3:0]  wcnt_q;
  logic [31:0] mid_q  [8];
  logic [31:0] tail_q [3];
  logic [31:0] nonce_q;
  logic [31:0] wk_q   [8];   // working variables a..h
  logic [31:0] w_q    [16];  // w_q[0] is the schedule word for the current round
  logic [6:0]  rnd_q;
  logic        rv_q, succ_q, nv_q;
  logic [31:0] nd_q;

  logic        accept, start_h1, pass;
  logic [31:0] t1, t2, w_new, d7_le, nonce_next, last_tail;

  // Round datapath and result test.
  always_comb begin
    t1 = wk_q[7]
       + (rotr(wk_q[4], 6) ^ rotr(wk_q[4], 11) ^ rotr(wk_q[4], 25))
       + ((wk_q[4] & wk_q[5]) ^ (~wk_q[4] & wk_q[6]))
       + K[rnd_q[5:0]] + w_q[0];
    t2 = (rotr(wk_q[0], 2) ^ rotr(wk_q[0], 13) ^ rotr(wk_q[0], 22))
       + ((wk_q[0] & wk_q[1]) ^ (wk_q[0] & wk_q[2]) ^ (wk_q[1] & wk_q[2]));
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10))
          + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3))
          + w_q[0];
    // CHECK overlaps the final IV add of the second hash.
    d7_le = bswap(wk_q[7] + IV[7]);
    pass  = (d7_le & ZMASK) == '0;
    // HASH1 is entered either straight from the 11th load word (tail W2 still
    // on blk_data) or from a failed CHECK with the next nonce.
    nonce_next = (state_q == S_CHECK) ? nonce_q + 32'd1 : NONCE_START;
    last_tail  = (state_q == S_CHECK) ? tail_q[2] : blk_data;
  end

  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    start_h1 = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (blk_valid) begin
          accept  = 1'b1;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (blk_valid) begin
          accept = 1'b1;
          if (wcnt_q == 4'd10) begin
            state_d  = S_HASH1;
            start_h1 = 1'b1;
          end
        end
      end
      S_HASH1: if (rnd_q == 7'd64) state_d = S_HASH2;
      S_HASH2: if (rnd_q == 7'd63) state_d = S_CHECK;
      S_CHECK: begin
        if (pass || nonce_q == NONCE_END) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_HASH1;
          start_h1 = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wcnt_q <= '0;
      rv_q   <= 1'b0;
      succ_q <= 1'b0;
      nv_q   <= 1'b0;
      nd_q   <= '0;
    end else begin
      rv_q <= 1'b0;
      nv_q <= 1'b0;
      if (accept) begin
        wcnt_q <= (wcnt_q == 4'd10) ? '0 : wcnt_q + 4'd1;
        if (state_q == S_IDLE) succ_q <= 1'b0;
      end
      if (state_q == S_CHECK && state_d == S_DONE) begin
        rv_q   <= 1'b1;
        succ_q <= pass;
        nv_q   <= pass;
        if (pass) nd_q <= nonce_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      if (wcnt_q < 4'd8)       mid_q[wcnt_q[2:0]] <= blk_data;
      else if (wcnt_q == 4'd8) tail_q[0] <= blk_data;
      else if (wcnt_q == 4'd9) tail_q[1] <= blk_data;
      else                     tail_q[2] <= blk_data;
    end

    if (start_h1) begin
      nonce_q <= nonce_next;
      rnd_q   <= '0;
      for (int unsigned i = 0; i < 8; i++) wk_q[i] <= mid_q[i];
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      w_q[0]  <= tail_q[0];
      w_q[1]  <= tail_q[1];
      w_q[2]  <= last_tail;
      w_q[3]  <= bswap(nonce_next);
      w_q[4]  <= 32'h8000_0000;
      w_q[15] <= 32'd640;
    end else if (state_q == S_HASH1 && rnd_q == 7'd64) begin
      // First digest becomes the second message; state restarts from IV.
      rnd_q <= '0;
      for (int unsigned i = 0; i < 8; i++) begin
        w_q[i]  <= wk_q[i] + mid_q[i];
        wk_q[i] <= IV[i];
      end
      for (int unsigned i = 9; i < 15; i++) w_q[i] <= '0;
      w_q[8]  <= 32'h8000_0000;
      w_q[15] <= 32'd256;
    end else if (state_q == S_HASH1 || state_q == S_HASH2) begin
      rnd_q   <= rnd_q + 7'd1;
      wk_q[0] <= t1 + t2;
      wk_q[1] <= wk_q[0];
      wk_q[2] <= wk_q[1];
      wk_q[3] <= wk_q[2];
      wk_q[4] <= wk_q[3] + t1;
      wk_q[5] <= wk_q[4];
      wk_q[6] <= wk_q[5];
      wk_q[7] <= wk_q[6];
      for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i + 1];
      w_q[15] <= w_new;
    end
  end

  assign resultValid = rv_q;
  assign success     = succ_q;
  assign non_valid   = nv_q;
  assign non_data    = nd_q;

endmodule

// File: tb/tb_bc_miner_core.sv
// Testbench for bc_miner_core: four instances with different search parameters,
// checked against a plain SHA-256 reference model of the nonce search.
module tb_bc_miner_core;

  typedef logic [0:7][31:0]  st_t;
  typedef logic [0:15][31:0] blk_t;
  typedef logic [0:10][31:0] job_t;

  localparam logic [0:63][31:0] KT = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam st_t IVM = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                         32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  // First 64 bytes of the genesis block header as big-endian words.
  localparam blk_t GEN_C0 = {32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                             32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
                             32'h888a5132, 32'h3a9fb8aa};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] data;
  logic [3:0]  bv, rv, sc, nv;
  logic [3:0][31:0] nd;
  int unsigned n_tests = 0, n_fail = 0;

  bc_miner_core #(.TARGET_ZEROS(32), .NONCE_START(32'h7C2BAC19), .NONCE_END(32'hFFFF_FFFF)) u_gen (
    .clk(clk), .rst(rst), .blk_valid(bv[0]), .blk_data(data),
    .resultValid(rv[0]), .success(sc[0]), .non_valid(nv[0]), .non_data(nd[0]));
  bc_miner_core #(.TARGET_ZEROS(32), .NONCE_START(32'h7C2BAC1C), .NONCE_END(32'h7C2BAC1C)) u_one (
    .clk(clk), .rst(rst), .blk_valid(bv[1]), .blk_data(data),
    .resultValid(rv[1]), .success(sc[1]), .non_valid(nv[1]), .non_data(nd[1]));
  bc_miner_core #(.TARGET_ZEROS(1), .NONCE_START(32'h0000_0000), .NONCE_END(32'hFFFF_FFFF)) u_easy (
    .clk(clk), .rst(rst), .blk_valid(bv[2]), .blk_data(data),
    .resultValid(rv[2]), .success(sc[2]), .non_valid(nv[2]), .non_data(nd[2]));
  bc_miner_core #(.TARGET_ZEROS(32), .NONCE_START(32'hFFFF_FFFE), .NONCE_END(32'hFFFF_FFFF)) u_top (
    .clk(clk), .rst(rst), .blk_valid(bv[3]), .blk_data(data),
    .resultValid(rv[3]), .success(sc[3]), .non_valid(nv[3]), .non_data(nd[3]));

  // ---------------- reference model ----------------
  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bs(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic st_t compress(input st_t h, input blk_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    st_t o;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    a = h[0]; b = h[1]; c = h[2]; d = h[3]; e = h[4]; f = h[5]; g = h[6]; hh = h[7];
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
      t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    o[0] = h[0] + a; o[1] = h[1] + b; o[2] = h[2] + c; o[3] = h[3] + d;
    o[4] = h[4] + e; o[5] = h[5] + f; o[6] = h[6] + g; o[7] = h[7] + hh;
    return o;
  endfunction

  function automatic st_t dbl_hash(input job_t j, input logic [31:0] n);
    st_t mid, h1;
    blk_t m1, m2;
    for (int i = 0; i < 8; i++) mid[i] = j[i];
    m1 = '0;
    m1[0] = j[8]; m1[1] = j[9]; m1[2] = j[10]; m1[3] = bs(n);
    m1[4] = 32'h8000_0000; m1[15] = 32'd640;
    h1 = compress(mid, m1);
    m2 = '0;
    for (int i = 0; i < 8; i++) m2[i] = h1[i];
    m2[8] = 32'h8000_0000; m2[15] = 32'd256;
    return compress(IVM, m2);
  endfunction

  function automatic bit meets(input st_t dg, input int tz);
    logic [31:0] v;
    v = bs(dg[7]);
    return (v >> (32 - tz)) == 32'd0;
  endfunction

  function automatic void model_search(input job_t j, input logic [31:0] s, input logic [31:0] e,
                                       input int tz, input int maxn,
                                       output bit found, output logic [31:0] nonce, output int tried);
    logic [31:0] n;
    bit fin;
    n = s; found = 1'b0; nonce = '0; tried = 0; fin = 1'b0;
    while (!fin) begin
      tried++;
      if (meets(dbl_hash(j, n), tz)) begin
        found = 1'b1; nonce = n; fin = 1'b1;
      end else if (n == e || tried >= maxn) begin
        fin = 1'b1;
      end else begin
        n = n + 32'd1;
      end
    end
  endfunction

  function automatic job_t genesis_job();
    job_t j;
    st_t m;
    m = compress(IVM, GEN_C0);
    for (int i = 0; i < 8; i++) j[i] = m[i];
    j[8] = 32'h4b1e5e4a; j[9] = 32'h29ab5f49; j[10] = 32'hffff001d;
    return j;
  endfunction

  function automatic job_t random_job();
    job_t j;
    for (int k = 0; k < 11; k++) j[k] = $urandom;
    return j;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drive_words(input int idx, input job_t j, input int from, input bit gaps);
    for (int k = from; k < 11; k++) begin
      if (gaps) step($urandom_range(0, 3));
      data = j[k]; bv[idx] = 1'b1;
      step(1);
      bv[idx] = 1'b0; data = $urandom;
    end
  endtask

  // Returns at the negedge where resultValid is seen; lat counts cycles from the
  // edge that took the last job word.
  task automatic wait_result(input int idx, input int budget, input bit toggle,
                             output bit got, output int lat, output bit succ,
                             output logic [31:0] nonce, output int nvc);
    int cyc;
    got = 1'b0; cyc = 0; succ = 1'b0; nonce = '0; nvc = 0;
    while (!got && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (nv[idx]) nvc++;
      if (rv[idx]) begin
        got = 1'b1; succ = sc[idx]; nonce = nd[idx];
      end else if (toggle) begin
        bv[idx] = 1'($urandom_range(0, 1)); data = $urandom;
      end
    end
    bv[idx] = 1'b0;
    lat = cyc - 1;
  endtask

  task automatic count_pulses(input int idx, input int n, output int rvc, output int nvc);
    rvc = 0; nvc = 0;
    repeat (n) begin
      @(negedge clk);
      if (rv[idx]) rvc++;
      if (nv[idx]) nvc++;
    end
    step(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_state();
    rst = 1'b0; bv = '0; data = '0;
    step(3);
    n_tests++;
    if ({rv, sc, nv} !== 12'h000) begin
      n_fail++; $display("FAIL reset_flags: got %h expected 000", {rv, sc, nv});
    end
    n_tests++;
    if (nd !== '0) begin
      n_fail++; $display("FAIL reset_non_data: got %h expected 0", nd);
    end
    rst = 1'b1;
    step(2);
  endtask

  task automatic run_genesis(input string tag);
    job_t j; bit got, succ; int lat, nvc; logic [31:0] an;
    j = genesis_job();
    drive_words(0, j, 0, 1'b0);
    wait_result(0, 5 * 130 + 30, 1'b0, got, lat, succ, an, nvc);
    n_tests++;
    if (!got) begin n_fail++; $display("FAIL %s_result: no resultValid within budget", tag); end
    n_tests++;
    if (succ !== 1'b1 || an !== 32'h7C2BAC1D) begin
      n_fail++; $display("FAIL %s_nonce: got success=%0b nonce=%h expected 1 7c2bac1d", tag, succ, an);
    end
    n_tests++;
    if (nvc !== 1) begin n_fail++; $display("FAIL %s_non_valid: got %0d pulses expected 1", tag, nvc); end
    n_tests++;
    if (lat !== 650) begin n_fail++; $display("FAIL %s_latency: got %0d expected 650", tag, lat); end
    @(negedge clk);
    n_tests++;
    if (rv[0] !== 1'b0 || nv[0] !== 1'b0 || sc[0] !== 1'b1 || nd[0] !== 32'h7C2BAC1D) begin
      n_fail++;
      $display("FAIL %s_hold: got rv=%0b nv=%0b sc=%0b nd=%h expected 0 0 1 7c2bac1d", tag, rv[0], nv[0], sc[0], nd[0]);
    end
    step(1);
  endtask

  task automatic test_genesis();
    st_t dg;
    dg = dbl_hash(genesis_job(), 32'h7C2BAC1D);
    n_tests++;
    if (dg[0] !== 32'h6fe28c0a || dg[6] !== 32'h68d61900 || dg[7] !== 32'h0) begin
      n_fail++; $display("FAIL model_genesis_hash: got %h %h %h expected 6fe28c0a 68d61900 0", dg[0], dg[6], dg[7]);
    end
    run_genesis("genesis");
  endtask

  task automatic test_reset_abort();
    job_t j; int rvc, nvc;
    j = genesis_job();
    drive_words(0, j, 0, 1'b0);
    step(300);
    rst = 1'b0;
    step(3);
    n_tests++;
    if (rv[0] !== 1'b0 || sc[0] !== 1'b0 || nv[0] !== 1'b0 || nd[0] !== 32'h0) begin
      n_fail++; $display("FAIL abort_reset_outputs: got rv=%0b sc=%0b nv=%0b nd=%h expected all 0", rv[0], sc[0], nv[0], nd[0]);
    end
    rst = 1'b1;
    count_pulses(0, 800, rvc, nvc);
    n_tests++;
    if (rvc !== 0 || nvc !== 0) begin
      n_fail++; $display("FAIL abort_no_result: got rv=%0d nv=%0d pulses expected 0 0", rvc, nvc);
    end
    for (int k = 0; k < 5; k++) begin
      data = j[k]; bv[0] = 1'b1; step(1); bv[0] = 1'b0;
    end
    rst = 1'b0;
    step(3);
    n_tests++;
    if (rv[0] !== 1'b0 || sc[0] !== 1'b0 || nv[0] !== 1'b0) begin
      n_fail++; $display("FAIL midload_reset_outputs: got rv=%0b sc=%0b nv=%0b expected 0 0 0", rv[0], sc[0], nv[0]);
    end
    rst = 1'b1;
    step(2);
    run_genesis("fresh_load");
  endtask

  task automatic test_not_found();
    bit got, succ; int lat, nvc, rvc, nvc2; logic [31:0] an;
    drive_words(1, genesis_job(), 0, 1'b0);
    wait_result(1, 200, 1'b0, got, lat, succ, an, nvc);
    n_tests++;
    if (!got || succ !== 1'b0) begin
      n_fail++; $display("FAIL not_found_result: got valid=%0b success=%0b expected 1 0", got, succ);
    end
    n_tests++;
    if (nvc !== 0) begin n_fail++; $display("FAIL not_found_non_valid: got %0d pulses expected 0", nvc); end
    n_tests++;
    if (lat !== 130) begin n_fail++; $display("FAIL not_found_latency: got %0d expected 130", lat); end
    count_pulses(1, 300, rvc, nvc2);
    n_tests++;
    if (rvc !== 0 || nvc2 !== 0) begin
      n_fail++; $display("FAIL not_found_quiet: got rv=%0d nv=%0d pulses expected 0 0", rvc, nvc2);
    end
  endtask

  task automatic test_nonce_end_max();
    bit f, got, succ; int tried, lat, nvc, rvc, nvc2; logic [31:0] en, an;
    model_search(genesis_job(), 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32, 8, f, en, tried);
    drive_words(3, genesis_job(), 0, 1'b0);
    wait_result(3, 130 * tried + 30, 1'b0, got, lat, succ, an, nvc);
    n_tests++;
    if (!got || succ !== f || lat !== 130 * tried) begin
      n_fail++; $display("FAIL end_max_result: got valid=%0b success=%0b lat=%0d expected 1 %0b %0d", got, succ, lat, f, 130 * tried);
    end
    count_pulses(3, 400, rvc, nvc2);
    n_tests++;
    if (rvc !== 0) begin n_fail++; $display("FAIL end_max_no_wrap: got %0d extra results expected 0", rvc); end
  endtask

  task automatic check_easy(input string tag, input job_t j, input bit gaps, input bit toggle);
    bit f, got, succ; int tried, lat, nvc; logic [31:0] en, an;
    model_search(j, 32'h0, 32'hFFFF_FFFF, 1, 40, f, en, tried);
    drive_words(2, j, 0, gaps);
    wait_result(2, 130 * tried + 30, toggle, got, lat, succ, an, nvc);
    n_tests++;
    if (!got || succ !== f) begin
      n_fail++; $display("FAIL %s_result: got valid=%0b success=%0b expected 1 %0b", tag, got, succ, f);
    end
    n_tests++;
    if (an !== en) begin n_fail++; $display("FAIL %s_nonce: got %h expected %h", tag, an, en); end
    n_tests++;
    if (nvc !== int'(f) || lat !== 130 * tried) begin
      n_fail++; $display("FAIL %s_timing: got nv=%0d lat=%0d expected %0d %0d", tag, nvc, lat, int'(f), 130 * tried);
    end
  endtask

  task automatic test_easy_target();
    for (int r = 0; r < 3; r++) begin
      check_easy("easy_target", random_job(), 1'b0, 1'b0);
      step(1);
    end
  endtask

  task automatic test_gaps_toggle();
    for (int r = 0; r < 2; r++) begin
      check_easy("gaps_toggle", random_job(), 1'b1, 1'b1);
      step(1);
    end
  endtask

  task automatic test_back_to_back();
    job_t j1, j2;
    bit f1;
    j1 = random_job();
    j2 = random_job();
    f1 = 1'b1;
    check_easy("b2b_job1", j1, 1'b0, 1'b0);
    // Word offered in the DONE cycle must be dropped.
    data = $urandom; bv[2] = 1'b1;
    step(1);
    bv[2] = 1'b0;
    n_tests++;
    if (sc[2] !== f1) begin n_fail++; $display("FAIL b2b_success_held: got %0b expected %0b", sc[2], f1); end
    data = j2[0]; bv[2] = 1'b1;
    step(1);
    bv[2] = 1'b0;
    n_tests++;
    if (sc[2] !== 1'b0) begin n_fail++; $display("FAIL b2b_success_cleared: got %0b expected 0", sc[2]); end
    begin
      bit f, got, succ; int tried, lat, nvc; logic [31:0] en, an;
      model_search(j2, 32'h0, 32'hFFFF_FFFF, 1, 40, f, en, tried);
      drive_words(2, j2, 1, 1'b0);
      wait_result(2, 130 * tried + 30, 1'b0, got, lat, succ, an, nvc);
      n_tests++;
      if (!got || succ !== f || an !== en || lat !== 130 * tried) begin
        n_fail++;
        $display("FAIL b2b_job2: got valid=%0b success=%0b nonce=%h lat=%0d expected 1 %0b %h %0d", got, succ, an, lat, f, en, 130 * tried);
      end
      step(1);
    end
  endtask

  initial begin
    test_reset_state();
    test_genesis();
    test_reset_abort();
    test_not_found();
    test_nonce_end_max();
    test_easy_target();
    test_gaps_toggle();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
